branch_predictor_2lvl: RTL
==========================

// Module: branch_predictor_2lvl
// PURPOSE
//  Parametrised two-level branch direction predictor for the IF stage; successor of the fixed 4/6-bit local predictor.
//  Mode select between per-PC local history and one shared global history; N-bit saturating counters.
//  Adds a registered query port, a self-clearing init sweep (no bulk reset of tables) and a mispredict statistic counter.
//  IF queries with the fetch PC; ROB commits resolved branch outcomes on the update port.
// PARAMETERS
//  ADDR_WIDTH  32  PC width
//  IDX_WIDTH   6   PC index bits, taken from PC[IDX_WIDTH+1:2]; BHT depth = 2**IDX_WIDTH
//  HIST_WIDTH  4   history register width; PHT depth = 2**(IDX_WIDTH+HIST_WIDTH)
//  CNT_WIDTH   2   saturating counter width (>=2)
//  GLOBAL_HIST 0   0: per-index local history (BHT); 1: one global history register (GHR)
//  STAT_WIDTH  16  mispredict counter width
// PORTS
//  clk          in   1           clock, all state on rising edge
//  rst_n_in     in   1           asynchronous, active-low reset
//  rdy_in       in   1           global stall; 0 freezes every register (incl. init sweep)
//  query_en     in   1           IF prediction request
//  query_pc     in   ADDR_WIDTH  fetch PC
//  pred_valid   out  1           prediction for last accepted query is valid
//  pred_taken   out  1           predicted direction (1 = taken)
//  upd_en       in   1           ROB commit of a resolved conditional branch
//  upd_pc       in   ADDR_WIDTH  PC of resolved branch
//  upd_taken    in   1           actual outcome
//  upd_pred     in   1           direction that was predicted for it
//  ready_out    out  1           init sweep done, tables usable
//  mispred_cnt  out  STAT_WIDTH  count of committed mispredictions
// BEHAVIOUR
//  Reset (async, rst_n_in=0): FSM->INIT, sweep ptr=0, GHR=0, pred_valid=0, pred_taken=0, ready_out=0, mispred_cnt=0.
//  INIT: each rdy_in cycle writes BHT[ptr]=0 and all 2**HIST_WIDTH PHT counters of row ptr to weakly-not-taken
//   (2**(CNT_WIDTH-1)-1); ptr++. After ptr=2**IDX_WIDTH-1 written -> RUN next cycle. Takes 2**IDX_WIDTH rdy cycles.
//  INIT: queries ignored (pred_valid stays 0), updates dropped, mispred_cnt unchanged.
//  RUN: ready_out=1. Reset assertion in any state restarts INIT from ptr=0.
//  Index: idx=PC[IDX_WIDTH+1:2]; hist = GLOBAL_HIST ? GHR : BHT[idx]; PHT address = {idx, hist}.
//  Query: accepted when RUN && rdy_in && query_en; next cycle pred_valid=1, pred_taken=MSB of counter read.
//   Cycle without accepted query: pred_valid=0, pred_taken holds. Latency exactly 1 cycle.
//  Update (RUN && rdy_in && upd_en), all at same edge, reads use pre-edge values:
//   counter at {idx_u, hist_u}: +1 if taken, -1 if not; saturate at 2**CNT_WIDTH-1 and 0 (no wrap).
//   history: hist_u <= {hist_u[HIST_WIDTH-2:0], upd_taken} (newest outcome in LSB, oldest dropped);
//    local mode writes BHT[idx_u], global mode writes GHR.
//   upd_pred!=upd_taken -> mispred_cnt+1, saturating at all-ones.
//  Simultaneous query+update to same PHT entry or history: query sees pre-update value (no forwarding).
//  Two updates cannot occur in one cycle (single port). rdy_in=0: no query accepted, pred_valid=0, nothing changes.
//  query_pc/upd_pc bits [1:0] and above IDX_WIDTH+1 ignored (aliasing by design).
// TESTING (defaults unless stated)
//  Reset, rdy_in=1 -> ready_out=0 for 64 cycles, 1 on 65th; query during INIT -> pred_valid never 1.
//  After init query 0x100 -> next cycle pred_valid=1, pred_taken=0; 2x upd_taken=1 for 0x100 (hist=0 and 1) then
//   pattern T,T,T,T fills hist=4'hF: 2 more updates at hist F -> query 0x100 predicts taken.
//  Local mode, train 0x200 with alternating T/N for 40 commits -> predictions match alternation (100% after warm-up),
//   while 0x204 still predicts not-taken (history isolation); GLOBAL_HIST=1: 0x204 shares GHR.
//  Saturation: 6 taken updates same entry -> counter 3, one not-taken -> still taken; 6 not-taken -> counter 0, no wrap.
//  Same-cycle query+update same entry at counter 1 with upd_taken=1 -> pred_taken=0, following query -> 1.
//  Drop rst_n_in mid-INIT (cycle 30) and mid-RUN -> outputs to reset values immediately; mispred_cnt=0;
//   STAT_WIDTH=4 with 20 mispredicts -> mispred_cnt=4'hF.

Source files
------------

// File: rtl/branch_predictor_2lvl.sv
// Two-level branch direction predictor: PC-indexed history (local BHT or one global GHR) selects
// a saturating counter in the PHT. Tables are cleared by a row-per-cycle init sweep after reset.
module branch_predictor_2lvl #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned IDX_WIDTH   = 6,
    parameter int unsigned HIST_WIDTH  = 4,
    parameter int unsigned CNT_WIDTH   = 2,
    parameter int unsigned GLOBAL_HIST = 0,
    parameter int unsigned STAT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  query_en,
    input  logic [ADDR_WIDTH-1:0] query_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    input  logic                  upd_en,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic                  upd_pred,
    output logic                  ready_out,
    output logic [STAT_WIDTH-1:0] mispred_cnt
);

    localparam int unsigned BHT_DEPTH  = 1 << IDX_WIDTH;
    localparam int unsigned HIST_DEPTH = 1 << HIST_WIDTH;
    localparam int unsigned PHT_DEPTH  = 1 << (IDX_WIDTH + HIST_WIDTH);
    localparam int unsigned PHT_AW     = IDX_WIDTH + HIST_WIDTH;

    localparam logic [CNT_WIDTH-1:0] CNT_WNT = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [IDX_WIDTH-1:0] PTR_LAST = {IDX_WIDTH{1'b1}};

    typedef enum logic {StInit, StRun} state_e;

    state_e                  r_state;
    logic [IDX_WIDTH-1:0]    r_ptr;
    logic [HIST_WIDTH-1:0]   r_ghr;
    logic                    r_pred_valid;
    logic                    r_pred_taken;
    logic                    r_ready;
    logic [STAT_WIDTH-1:0]   r_mispred;

    logic [HIST_WIDTH-1:0]   r_bht [BHT_DEPTH];
    logic [CNT_WIDTH-1:0]    r_pht [PHT_DEPTH];

    logic [IDX_WIDTH-1:0]    w_q_idx;
    logic [HIST_WIDTH-1:0]   w_q_hist;
    logic [PHT_AW-1:0]       w_q_addr;
    logic [CNT_WIDTH-1:0]    w_q_cnt;
    logic [IDX_WIDTH-1:0]    w_u_idx;
    logic [HIST_WIDTH-1:0]   w_u_hist;
    logic [HIST_WIDTH-1:0]   w_u_hist_nxt;
    logic [PHT_AW-1:0]       w_u_addr;
    logic [CNT_WIDTH-1:0]    w_u_cnt;
    logic [CNT_WIDTH-1:0]    w_u_cnt_nxt;
    logic                    w_run;
    logic                    w_q_acc;
    logic                    w_u_acc;
    logic                    w_mispred;
    logic                    w_unused_pc;

    // PC bits outside the index field are intentionally aliased away.
    assign w_unused_pc = ^{query_pc[1:0], query_pc[ADDR_WIDTH-1:IDX_WIDTH+2],
                           upd_pc[1:0], upd_pc[ADDR_WIDTH-1:IDX_WIDTH+2]};

    assign w_q_idx  = query_pc[IDX_WIDTH+1:2];
    assign w_q_hist = (GLOBAL_HIST != 0) ? r_ghr : r_bht[w_q_idx];
    assign w_q_addr = {w_q_idx, w_q_hist};
    assign w_q_cnt  = r_pht[w_q_addr];

    assign w_u_idx      = upd_pc[IDX_WIDTH+1:2];
    assign w_u_hist     = (GLOBAL_HIST != 0) ? r_ghr : r_bht[w_u_idx];
    assign w_u_hist_nxt = {w_u_hist[HIST_WIDTH-2:0], upd_taken};
    assign w_u_addr     = {w_u_idx, w_u_hist};
    assign w_u_cnt      = r_pht[w_u_addr];

    assign w_run     = (r_state == StRun);
    assign w_q_acc   = w_run && rdy_in && query_en;
    assign w_u_acc   = w_run && rdy_in && upd_en;
    assign w_mispred = w_u_acc && (upd_pred != upd_taken);

    always_comb begin
        w_u_cnt_nxt = w_u_cnt;
        if (upd_taken) begin
            if (w_u_cnt != CNT_MAX) w_u_cnt_nxt = w_u_cnt + 1'b1;
        end else begin
            if (w_u_cnt != '0) w_u_cnt_nxt = w_u_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= StInit;
            r_ptr        <= '0;
            r_ghr        <= '0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_ready      <= 1'b0;
            r_mispred    <= '0;
        end else if (rdy_in) begin
            case (r_state)
                StInit: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == PTR_LAST) begin
                        r_state <= StRun;
                        r_ready <= 1'b1;
                    end
                end
                StRun: begin
                    r_ready <= 1'b1;
                end
                default: r_state <= StInit;
            endcase
            r_pred_valid <= w_q_acc;
            if (w_q_acc) r_pred_taken <= w_q_cnt[CNT_WIDTH-1];
            if (w_u_acc && (GLOBAL_HIST != 0)) r_ghr <= w_u_hist_nxt;
            if (w_mispred && (r_mispred != {STAT_WIDTH{1'b1}})) r_mispred <= r_mispred + 1'b1;
        end else begin
            r_pred_valid <= 1'b0;
        end
    end

    // Tables carry no reset; the init sweep clears one BHT entry and one PHT row per cycle.
    always_ff @(posedge clk) begin
        if (rdy_in) begin
            if (r_state == StInit) begin
                r_bht[r_ptr] <= '0;
                for (int h = 0; h < HIST_DEPTH; h++) begin
                    r_pht[{r_ptr, HIST_WIDTH'(h)}] <= CNT_WNT;
                end
            end else if (w_u_acc) begin
                r_pht[w_u_addr] <= w_u_cnt_nxt;
                if (GLOBAL_HIST == 0) r_bht[w_u_idx] <= w_u_hist_nxt;
            end
        end
    end

    assign pred_valid  = r_pred_valid;
    assign pred_taken  = r_pred_taken;
    assign ready_out   = r_ready;
    assign mispred_cnt = r_mispred;

endmodule
